// File: rtl/eth_pkg.sv
// Shared constants, state encoding and header helper for the Ethernet frame path.
package eth_pkg;

    localparam int unsigned ETH_HDR_BYTES   = 14;
    localparam int unsigned ETH_FCS_BYTES   = 4;
    localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
    localparam int unsigned ETH_MIN_PAYLOAD = 46;
    localparam int unsigned ETH_MAX_PAYLOAD = 1500;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StPay,
        StPad,
        StFcs
    } tx_state_t;

    // Header byte idx of {da, sa, len}, MSB first; out-of-range idx yields 0.
    function automatic logic [7:0] hdr_byte(input logic [47:0] da, input logic [47:0] sa,
                                            input logic [15:0] len, input logic [3:0] idx);
        logic [111:0] hdr;
        hdr = {da, sa, len};
        return 8'(hdr >> (8 * (32'(ETH_HDR_BYTES - 1) - 32'(idx))));
    endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational byte-wise CRC-32 step (reflected polynomial, LSB first).
module eth_crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] c;

    always_comb begin
        c = crc_i ^ {24'h0, data_i};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/eth_frame_tx.sv
// Ethernet frame transmitter: header, pass-through payload, zero pad and FCS on a
// byte-wide valid/ready stream.
module eth_frame_tx
    import eth_pkg::*;
#(
    parameter int unsigned MIN_PAYLOAD = ETH_MIN_PAYLOAD,
    parameter int unsigned MAX_PAYLOAD = ETH_MAX_PAYLOAD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [47:0] da,
    input  logic [47:0] sa,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic [7:0]  data_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic [7:0]  data_out,
    output logic        valid_out,
    input  logic        ready_in
);

    localparam logic [15:0] MinLen  = 16'(MIN_PAYLOAD);
    localparam logic [15:0] MaxLen  = 16'(MAX_PAYLOAD);
    localparam logic [15:0] LastHdr = 16'(ETH_HDR_BYTES - 1);
    localparam logic [15:0] LastFcs = 16'(ETH_FCS_BYTES - 1);

    tx_state_t   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] len_q, len_d;
    logic [47:0] da_q, da_d;
    logic [47:0] sa_q, sa_d;
    logic [31:0] crc_q, crc_d;
    logic [31:0] crc_next;
    logic [31:0] fcs;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        hs;
    logic        len_ok;
    logic        last_hdr, last_pay, last_pad, last_fcs;

    assign hs       = valid_out & ready_in;
    assign len_ok   = (len != 16'd0) && (len <= MaxLen);
    assign fcs      = ~crc_q;
    assign last_hdr = (cnt_q == LastHdr);
    assign last_pay = (cnt_q == len_q - 16'd1);
    assign last_pad = (cnt_q == MinLen - 16'd1);
    assign last_fcs = (cnt_q == LastFcs);

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign err  = err_q;

    eth_crc32_byte u_crc (
        .crc_i  (crc_q),
        .data_i (data_out),
        .crc_o  (crc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start && len_ok) state_d = StHdr;
            StHdr:  if (hs && last_hdr) state_d = StPay;
            StPay:  if (hs && last_pay) state_d = (len_q < MinLen) ? StPad : StFcs;
            StPad:  if (hs && last_pad) state_d = StFcs;
            StFcs:  if (hs && last_fcs) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outside PAY the byte is a pure function of registers, so it holds under stall.
    always_comb begin
        data_out  = 8'h00;
        valid_out = 1'b0;
        ready_out = 1'b0;
        unique case (state_q)
            StIdle: ;
            StHdr: begin
                valid_out = 1'b1;
                data_out  = hdr_byte(da_q, sa_q, len_q, cnt_q[3:0]);
            end
            StPay: begin
                valid_out = valid_in;
                data_out  = data_in;
                ready_out = ready_in;
            end
            StPad: valid_out = 1'b1;
            StFcs: begin
                valid_out = 1'b1;
                data_out  = 8'(fcs >> {cnt_q[1:0], 3'b000});
            end
            default: ;
        endcase
    end

    // PAY->PAD keeps counting so the pad stops when payload plus pad reaches MinLen.
    always_comb begin
        cnt_d  = cnt_q;
        len_d  = len_q;
        da_d   = da_q;
        sa_d   = sa_q;
        crc_d  = crc_q;
        done_d = 1'b0;
        err_d  = 1'b0;
        if (state_q == StIdle) begin
            if (start && len_ok) begin
                da_d  = da;
                sa_d  = sa;
                len_d = len;
                crc_d = ETH_CRC_INIT;
                cnt_d = '0;
            end else if (start) begin
                err_d = 1'b1;
            end
        end else if (hs) begin
            if (state_q != StFcs) crc_d = crc_next;
            cnt_d  = (state_d != state_q && state_d != StPad) ? '0 : cnt_q + 16'd1;
            done_d = (state_d == StIdle);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            len_q  <= '0;
            da_q   <= '0;
            sa_q   <= '0;
            crc_q  <= ETH_CRC_INIT;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            len_q  <= len_d;
            da_q   <= da_d;
            sa_q   <= sa_d;
            crc_q  <= crc_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_eth_frame_tx.sv
// Bench for eth_frame_tx: random payloads and backpressure against a queue-based frame model.
module tb_eth_frame_tx;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [47:0] da, sa;
    logic [15:0] len;
    logic        busy, done, err;
    logic [7:0]  data_in;
    logic        valid_in;
    logic        ready_out;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        ready_in;

    eth_frame_tx #(
        .MIN_PAYLOAD (46),
        .MAX_PAYLOAD (1500)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .da        (da),
        .sa        (sa),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [31:0] crc_tab[256];

    bq_t pay;
    int  pay_idx   = 0;
    bit  src_flush = 1'b0;
    bit  src_fired = 1'b0;
    int  vin_pct   = 100;

    int rmode      = 0;
    int stall_trig[$];
    int stall_left = 0;

    bq_t        got;
    int         hs_cyc[$];
    int         done_cnt  = 0;
    int         err_cnt   = 0;
    int         rdy_hs    = 0;
    int         stab_viol = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    // Payload source: holds each byte until it is taken.
    initial begin
        valid_in = 1'b0;
        data_in  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (src_flush) begin
                valid_in  = 1'b0;
                src_flush = 1'b0;
            end else begin
                if (src_fired) begin
                    pay_idx++;
                    valid_in = 1'b0;
                end
                if (!valid_in && pay_idx < pay.size() && $urandom_range(99) < vin_pct) begin
                    valid_in = 1'b1;
                    data_in  = pay[pay_idx];
                end
            end
        end
    end

    // Sink ready: always, random 50%, plus 20-cycle holds at chosen byte counts.
    initial begin
        ready_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                ready_in = 1'b0;
                stall_left--;
            end else if (stall_trig.size() > 0 && got.size() >= stall_trig[0]) begin
                void'(stall_trig.pop_front());
                stall_left = 19;
                ready_in   = 1'b0;
            end else begin
                ready_in = (rmode == 0) ? 1'b1 : 1'($urandom_range(1));
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        src_fired = valid_in && ready_out && !rst;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (valid_out !== 1'b1 || data_out !== prev_data)) stab_viol++;
            prev_stall = valid_out && !ready_in;
            prev_data  = data_out;
            if (valid_out && ready_in) begin
                got.push_back(data_out);
                hs_cyc.push_back(cyc);
            end
            if (valid_in && ready_out) rdy_hs++;
            if (done) done_cnt++;
            if (err) err_cnt++;
        end
    end

    function automatic int first_diff(input bq_t a, input bq_t b);
        int n = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
        if (a.size() != b.size()) return n;
        return -1;
    endfunction

    // Reference frame: header, payload, zero pad to 46, then table-driven CRC-32 LSB first.
    task automatic build_frame(input logic [47:0] fda, input logic [47:0] fsa,
                               input logic [15:0] flen, input bq_t pl, output bq_t fr);
        logic [31:0] c;
        fr = {};
        for (int i = 0; i < 6; i++) fr.push_back(fda[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) fr.push_back(fsa[47-8*i -: 8]);
        fr.push_back(flen[15:8]);
        fr.push_back(flen[7:0]);
        foreach (pl[i]) fr.push_back(pl[i]);
        while (fr.size() < 14 + 46) fr.push_back(8'h00);
        c = 32'hFFFFFFFF;
        foreach (fr[i]) c = crc_tab[8'(c ^ {24'h0, fr[i]})] ^ (c >> 8);
        c = ~c;
        for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
    endtask

    task automatic rand_payload(input int n, output bq_t p);
        p = {};
        for (int i = 0; i < n; i++) p.push_back(8'($urandom));
    endtask

    function automatic logic [47:0] rand_mac();
        return {16'($urandom), 32'($urandom)};
    endfunction

    task automatic clear_mon();
        got.delete();
        hs_cyc.delete();
        done_cnt  = 0;
        err_cnt   = 0;
        rdy_hs    = 0;
        stab_viol = 0;
    endtask

    task automatic load_payload(input bq_t p);
        pay       = p;
        pay_idx   = 0;
        src_flush = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [47:0] fda, input logic [47:0] fsa,
                               input logic [15:0] flen);
        da    = fda;
        sa    = fsa;
        len   = flen;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget, output bit tmo);
        for (int c = 0; c < budget && done_cnt < n; c++) begin
            @(posedge clk);
            #1;
        end
        tmo = (done_cnt < n);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({valid_out, ready_out, busy, done, err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %05b want 00000",
                     {valid_out, ready_out, busy, done, err});
        end
        checks++;
        if (data_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: got %02h want 00", data_out);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (valid_out !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: valid_out=%b busy=%b want 0 0", valid_out, busy);
        end
    endtask

    task automatic test_basic();
        bq_t p, exp;
        bit  tmo;
        int  d;
        for (int i = 0; i < 64; i++) p.push_back(8'(i));
        build_frame({48{1'b1}}, 48'h001122334455, 16'd64, p, exp);
        rmode   = 0;
        vin_pct = 100;
        load_payload(p);
        clear_mon();
        start_frame({48{1'b1}}, 48'h001122334455, 16'd64);
        checks++;
        if (valid_out !== 1'b1 || data_out !== 8'hFF || busy !== 1'b1) begin
            failures++;
            $display("FAIL start_latency: valid=%b data=%02h busy=%b want 1 ff 1",
                     valid_out, data_out, busy);
        end
        wait_done(1, 300, tmo);
        checks++;
        if (tmo) begin
            failures++;
            $display("FAIL basic_timeout: done_cnt=%0d want 1", done_cnt);
        end
        checks++;
        if (got.size() != 82) begin
            failures++;
            $display("FAIL basic_len: got %0d bytes want 82", got.size());
        end
        checks++;
        if (got.size() < 14 || got[12] !== 8'h00 || got[13] !== 8'h40) begin
            failures++;
            $display("FAIL basic_lenfield: got %02h%02h want 0040", got[12], got[13]);
        end
        d = first_diff(got, exp);
        checks++;
        if (d >= 0) begin
            failures++;
            $display("FAIL basic_frame: byte %0d got %02h want %02h (sizes %0d/%0d)",
                     d, got[d], exp[d], got.size(), exp.size());
        end
        checks++;
        if (hs_cyc.size() != 82 || hs_cyc[81] - hs_cyc[0] != 81) begin
            failures++;
            $display("FAIL basic_contiguous: got %0d bytes over %0d cycles want 82 over 81",
                     hs_cyc.size(), hs_cyc[hs_cyc.size()-1] - hs_cyc[0]);
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL basic_done: got %0d pulses want 1", done_cnt);
        end
    endtask

    task automatic test_padding();
        bq_t p, exp;
        bit  tmo;
        int  d, nz;
        logic [47:0] fda, fsa;
        fda = rand_mac();
        fsa = rand_mac();
        p   = {8'hA5};
        build_frame(fda, fsa, 16'd1, p, exp);
        load_payload(p);
        clear_mon();
        start_frame(fda, fsa, 16'd1);
        wait_done(1, 300, tmo);
        checks++;
        if (tmo || got.size() != 64) begin
            failures++;
            $display("FAIL pad_len: got %0d bytes timeout=%b want 64 0", got.size(), tmo);
        end
        checks++;
        if (got[14] !== 8'hA5) begin
            failures++;
            $display("FAIL pad_payload: got %02h want a5", got[14]);
        end
        nz = 0;
        for (int i = 15; i < 60; i++) if (got[i] !== 8'h00) nz++;
        checks++;
        if (nz != 0) begin
            failures++;
            $display("FAIL pad_zeros: got %0d nonzero pad bytes want 0", nz);
        end
        d = first_diff(got, exp);
        checks++;
        if (d >= 0) begin
            failures++;
            $display("FAIL pad_frame: byte %0d got %02h want %02h", d, got[d], exp[d]);
        end
        checks++;
        if (rdy_hs != 1) begin
            failures++;
            $display("FAIL pad_ready_out: got %0d payload handshakes want 1", rdy_hs);
        end
    endtask

    task automatic test_backpressure();
        bq_t p, exp, ref_run;
        bit  tmo;
        int  d;
        logic [47:0] fda, fsa;
        fda = rand_mac();
        fsa = rand_mac();
        rand_payload(100, p);
        build_frame(fda, fsa, 16'd100, p, exp);
        rmode   = 0;
        vin_pct = 100;
        load_payload(p);
        clear_mon();
        start_frame(fda, fsa, 16'd100);
        wait_done(1, 400, tmo);
        ref_run = got;
        rmode   = 1;
        vin_pct = 60;
        load_payload(p);
        clear_mon();
        stall_trig = '{5, exp.size() - 2};
        start_frame(fda, fsa, 16'd100);
        wait_done(1, 3000, tmo);
        checks++;
        if (tmo) begin
            failures++;
            $display("FAIL bp_timeout: done_cnt=%0d want 1", done_cnt);
        end
        d = first_diff(got, ref_run);
        checks++;
        if (d >= 0) begin
            failures++;
            $display("FAIL bp_vs_nostall: byte %0d got %02h want %02h", d, got[d], ref_run[d]);
        end
        d = first_diff(got, exp);
        checks++;
        if (d >= 0) begin
            failures++;
            $display("FAIL bp_frame: byte %0d got %02h want %02h", d, got[d], exp[d]);
        end
        checks++;
        if (stab_viol != 0) begin
            failures++;
            $display("FAIL bp_stable: got %0d stall violations want 0", stab_viol);
        end
        rmode   = 0;
        vin_pct = 100;
        stall_trig.delete();
    endtask

    task automatic test_illegal();
        logic [15:0] bad_len[2];
        bad_len = '{16'd0, 16'd1501};
        clear_mon();
        for (int k = 0; k < 2; k++) begin
            da    = rand_mac();
            sa    = rand_mac();
            len   = bad_len[k];
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            checks++;
            if (err !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL illegal_err len=%0d: err=%b busy=%b want 1 0", bad_len[k], err, busy);
            end
            @(posedge clk);
            #1;
            checks++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL illegal_after len=%0d: err=%b busy=%b want 0 0",
                         bad_len[k], err, busy);
            end
        end
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (got.size() != 0 || err_cnt != 2) begin
            failures++;
            $display("FAIL illegal_quiet: got %0d bytes %0d errs want 0 2", got.size(), err_cnt);
        end
    endtask

    task automatic test_overlap();
        bq_t p, exp;
        int  d;
        logic [47:0] fda, fsa;
        fda = rand_mac();
        fsa = rand_mac();
        rand_payload(50, p);
        build_frame(fda, fsa, 16'd50, p, exp);
        load_payload(p);
        clear_mon();
        start_frame(fda, fsa, 16'd50);
        for (int c = 0; c < 400 && done_cnt < 1; c++) begin
            start = 1'b0;
            if (got.size() >= 20 && got.size() < 23) begin
                da    = ~fda;
                len   = 16'd10;
                start = 1'b1;
            end else if (got.size() >= 40 && got.size() < 42) begin
                len   = 16'd0;
                start = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        d = first_diff(got, exp);
        checks++;
        if (d >= 0) begin
            failures++;
            $display("FAIL overlap_frame: byte %0d got %02h want %02h (sizes %0d/%0d)",
                     d, got[d], exp[d], got.size(), exp.size());
        end
        checks++;
        if (err_cnt != 0 || done_cnt != 1) begin
            failures++;
            $display("FAIL overlap_flags: errs=%0d dones=%0d want 0 1", err_cnt, done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bq_t p, exp;
        bit  tmo;
        int  d;
        logic [47:0] fda, fsa;
        fda = rand_mac();
        fsa = rand_mac();
        rand_payload(60, p);
        load_payload(p);
        clear_mon();
        start_frame(fda, fsa, 16'd60);
        for (int c = 0; c < 200 && got.size() < 24; c++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (got.size() != 24) begin
            failures++;
            $display("FAIL rstmid_reach: got %0d bytes want 24", got.size());
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (valid_out !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async: valid_out=%b busy=%b want 0 0", valid_out, busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (valid_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_next: valid=%b busy=%b done=%b want 0 0 0",
                     valid_out, busy, done);
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != 0) begin
            failures++;
            $display("FAIL rstmid_nodone: got %0d pulses want 0", done_cnt);
        end
        fda = rand_mac();
        rand_payload(60, p);
        build_frame(fda, fsa, 16'd60, p, exp);
        load_payload(p);
        clear_mon();
        start_frame(fda, fsa, 16'd60);
        wait_done(1, 300, tmo);
        d = first_diff(got, exp);
        checks++;
        if (tmo || d >= 0) begin
            failures++;
            $display("FAIL rstmid_frame: timeout=%b byte %0d got %02h want %02h",
                     tmo, d, got[d], exp[d]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] lens[3];
        logic [47:0] das[3], sas[3];
        bq_t p, all_p, f, exp_all, one_got, one_exp;
        int  sizes[3];
        int  base, n, d, last;
        bit  tmo;
        lens = '{16'd46, 16'd47, 16'd1500};
        for (int k = 0; k < 3; k++) begin
            das[k] = rand_mac();
            sas[k] = rand_mac();
            rand_payload(int'(lens[k]), p);
            foreach (p[i]) all_p.push_back(p[i]);
            build_frame(das[k], sas[k], lens[k], p, f);
            sizes[k] = f.size();
            foreach (f[i]) exp_all.push_back(f[i]);
        end
        load_payload(all_p);
        clear_mon();
        start_frame(das[0], sas[0], lens[0]);
        n = 1;
        for (int c = 0; c < 2500 && done_cnt < 3; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done === 1'b1 && n < 3) begin
                da    = das[n];
                sa    = sas[n];
                len   = lens[n];
                start = 1'b1;
                n++;
            end
        end
        start = 1'b0;
        wait_done(3, 10, tmo);
        checks++;
        if (tmo || done_cnt != 3) begin
            failures++;
            $display("FAIL b2b_done: got %0d pulses want 3", done_cnt);
        end
        base = 0;
        for (int k = 0; k < 3; k++) begin
            one_got = {};
            one_exp = {};
            for (int i = 0; i < sizes[k]; i++) begin
                one_got.push_back(got[base + i]);
                one_exp.push_back(exp_all[base + i]);
            end
            d = first_diff(one_got, one_exp);
            checks++;
            if (d >= 0) begin
                failures++;
                $display("FAIL b2b_frame%0d: byte %0d got %02h want %02h",
                         k, d, one_got[d], one_exp[d]);
            end
            base += sizes[k];
            if (k < 2) begin
                last = base - 1;
                checks++;
                if (hs_cyc.size() <= base || hs_cyc[base] - hs_cyc[last] != 2) begin
                    failures++;
                    $display("FAIL b2b_gap%0d: got %0d cycles between frames want 2",
                             k, (hs_cyc.size() > base) ? hs_cyc[base] - hs_cyc[last] : -1);
                end
            end
        end
        checks++;
        if (got.size() != exp_all.size()) begin
            failures++;
            $display("FAIL b2b_total: got %0d bytes want %0d", got.size(), exp_all.size());
        end
    endtask

    initial begin
        logic [31:0] c;
        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[i] = c;
        end
        rst   = 1'b1;
        start = 1'b0;
        da    = '0;
        sa    = '0;
        len   = '0;
        test_reset();
        test_basic();
        test_padding();
        test_backpressure();
        test_illegal();
        test_overlap();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
